// File: rtl/piso_serializer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : piso_serializer_if                                 |
// | Description : Parallel-word handshake and serial bit stream bus  |
// |               for the PISO serializer.                           |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+

interface piso_serializer_if #(
    parameter int WIDTH = 4
) ();

    logic             par_valid_i;
    logic [WIDTH-1:0] par_data_i;
    logic             par_ready_o;
    logic             ser_en_i;
    logic             x_o;
    logic             x_valid_o;
    logic             x_first_o;
    logic             x_last_o;
    logic             busy_o;

    // Upstream producer and downstream consumer together.
    modport master (
        output par_valid_i,
        output par_data_i,
        output ser_en_i,
        input  par_ready_o,
        input  x_o,
        input  x_valid_o,
        input  x_first_o,
        input  x_last_o,
        input  busy_o
    );

    // The serializer itself.
    modport slave (
        input  par_valid_i,
        input  par_data_i,
        input  ser_en_i,
        output par_ready_o,
        output x_o,
        output x_valid_o,
        output x_first_o,
        output x_last_o,
        output busy_o
    );

endinterface

`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : piso_serializer                                    |
// | Description : Parallel-in serial-out shifter with valid/ready    |
// |               word intake, stallable bit stream and first/last   |
// |               markers; back-to-back words without idle gaps.     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+

module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire              clk,
    input  wire              reset,
    piso_serializer_if.slave bus
);

    localparam int                c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
    localparam int                c_out_idx  = MSB_FIRST ? (WIDTH - 1) : 0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_sr;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_first;
    logic                 r_last;

    state_t               w_state_nxt;
    logic [WIDTH-1:0]     w_sr_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 w_first_nxt;
    logic                 w_last_nxt;

    logic                 w_at_last;
    logic                 w_ready;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_shifted;
    logic [c_cnt_w-1:0]   w_cnt_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_first <= w_first_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_at_last   = (r_state == ST_SHIFT) && (r_cnt == c_last_cnt);
        // Ready in SHIFT only while the final bit is being consumed, so the
        // next word lands on the same edge and the stream has no gap.
        w_ready     = (r_state == ST_IDLE) || (w_at_last && bus.ser_en_i);
        w_accept    = bus.par_valid_i && w_ready;
        w_shifted   = MSB_FIRST ? (r_sr << 1) : (r_sr >> 1);
        w_cnt_inc   = r_cnt + 1'b1;

        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_first_nxt = r_first;
        w_last_nxt  = r_last;

        if (w_accept) begin
            w_state_nxt = ST_SHIFT;
            w_sr_nxt    = bus.par_data_i;
            w_cnt_nxt   = '0;
            w_first_nxt = 1'b1;
            w_last_nxt  = (WIDTH == 1);
        end else if ((r_state == ST_SHIFT) && bus.ser_en_i) begin
            if (w_at_last) begin
                // Clearing the register keeps x_o at 0 while idle.
                w_state_nxt = ST_IDLE;
                w_sr_nxt    = '0;
                w_cnt_nxt   = '0;
                w_first_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end else begin
                w_sr_nxt    = w_shifted;
                w_cnt_nxt   = w_cnt_inc;
                w_first_nxt = 1'b0;
                w_last_nxt  = (w_cnt_inc == c_last_cnt);
            end
        end
    end

    assign bus.par_ready_o = w_ready;
    assign bus.x_o         = r_sr[c_out_idx];
    assign bus.x_valid_o   = (r_state == ST_SHIFT);
    assign bus.busy_o      = (r_state == ST_SHIFT);
    assign bus.x_first_o   = r_first;
    assign bus.x_last_o    = r_last;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_piso_serializer                                 |
// | Description : Scoreboard bench for piso_serializer (W4 MSB/LSB,  |
// |               W1).                                               |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+

module tb_piso_serializer;

    typedef struct packed {
        logic x;
        logic first;
        logic last;
    } exp_bit_t;

    logic       clk;
    logic       reset;
    logic [1:0] sel;
    logic       par_valid;
    logic [3:0] par_data;
    logic       ser_en;

    logic o_x, o_xv, o_first, o_last, o_busy, o_ready;

    exp_bit_t   sb[$];
    logic [3:0] words[$];
    logic [3:0] rx;
    int         errors;
    int         checks;

    piso_serializer_if #(.WIDTH(4)) if_m ();
    piso_serializer_if #(.WIDTH(4)) if_l ();
    piso_serializer_if #(.WIDTH(1)) if_1 ();

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(if_m));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(if_l));
    piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_1 (.clk(clk), .reset(reset), .bus(if_1));

    assign if_m.par_valid_i = par_valid && (sel == 2'd0);
    assign if_m.par_data_i  = par_data;
    assign if_m.ser_en_i    = ser_en && (sel == 2'd0);
    assign if_l.par_valid_i = par_valid && (sel == 2'd1);
    assign if_l.par_data_i  = par_data;
    assign if_l.ser_en_i    = ser_en && (sel == 2'd1);
    assign if_1.par_valid_i = par_valid && (sel == 2'd2);
    assign if_1.par_data_i  = par_data[0];
    assign if_1.ser_en_i    = ser_en && (sel == 2'd2);

    always_comb begin
        {o_x, o_xv, o_first, o_last, o_busy, o_ready} = '0;
        case (sel)
            2'd0: {o_x, o_xv, o_first, o_last, o_busy, o_ready} =
                  {if_m.x_o, if_m.x_valid_o, if_m.x_first_o, if_m.x_last_o, if_m.busy_o, if_m.par_ready_o};
            2'd1: {o_x, o_xv, o_first, o_last, o_busy, o_ready} =
                  {if_l.x_o, if_l.x_valid_o, if_l.x_first_o, if_l.x_last_o, if_l.busy_o, if_l.par_ready_o};
            2'd2: {o_x, o_xv, o_first, o_last, o_busy, o_ready} =
                  {if_1.x_o, if_1.x_valid_o, if_1.x_first_o, if_1.x_last_o, if_1.busy_o, if_1.par_ready_o};
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected bit order for the selected instance, pushed when the word is accepted.
    task automatic push_word(input logic [3:0] d);
        int       w;
        int       idx;
        logic     msb;
        exp_bit_t e;
        w   = (sel == 2'd2) ? 1 : 4;
        msb = (sel != 2'd1);
        for (int i = 0; i < w; i++) begin
            idx     = msb ? (w - 1 - i) : i;
            e.x     = d[idx];
            e.first = (i == 0);
            e.last  = (i == w - 1);
            sb.push_back(e);
        end
        if (sel == 2'd0) words.push_back(d);
    endtask

    task automatic drive_cycle(input logic v, input logic [3:0] d, input logic e, input string tag);
        exp_bit_t   head;
        logic       exp_rdy;
        logic       accept;
        logic       consume;
        logic       seen_x;
        logic [3:0] exp_word;
        par_valid = v;
        par_data  = d;
        ser_en    = e;
        @(negedge clk);
        seen_x = o_x;
        if (sb.size() == 0) begin
            exp_rdy = 1'b1;
            consume = 1'b0;
            checks++;
            if ({o_xv, o_busy, o_x, o_first, o_last} !== 5'b00000) begin
                errors++;
                $display("FAIL %s idle_outputs: got valid,busy,x,first,last=%b required 00000",
                         tag, {o_xv, o_busy, o_x, o_first, o_last});
            end
        end else begin
            head    = sb[0];
            exp_rdy = head.last & e;
            consume = e;
            checks++;
            if ({o_xv, o_busy, o_x, o_first, o_last} !== {2'b11, head.x, head.first, head.last}) begin
                errors++;
                $display("FAIL %s bit_outputs: got valid,busy,x,first,last=%b required %b",
                         tag, {o_xv, o_busy, o_x, o_first, o_last}, {2'b11, head.x, head.first, head.last});
            end
        end
        checks++;
        if (o_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s par_ready: got %b required %b", tag, o_ready, exp_rdy);
        end
        accept = v & exp_rdy;
        @(posedge clk);
        if (consume) begin
            head = sb.pop_front();
            if (sel == 2'd0) begin
                rx = {rx[2:0], seen_x};
                if (head.last && words.size() > 0) begin
                    exp_word = words.pop_front();
                    checks++;
                    if (rx !== exp_word) begin
                        errors++;
                        $display("FAIL %s receiver_word: got %h required %h", tag, rx, exp_word);
                    end
                end
            end
        end
        if (accept) push_word(d);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        par_valid = 1'b0;
        par_data  = 4'h0;
        ser_en    = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if ({o_xv, o_busy, o_x, o_first, o_last, o_ready} !== 6'b000001) begin
                errors++;
                $display("FAIL reset_state sel%0d: got valid,busy,x,first,last,ready=%b required 000001",
                         s, {o_xv, o_busy, o_x, o_first, o_last, o_ready});
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sel   = 2'd0;
    endtask

    task automatic test_msb_first();
        sel = 2'd0;
        drive_cycle(1'b1, 4'hA, 1'b1, "msb_load");
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 4'(i * 5), 1'b1, "msb_bits");
        drive_cycle(1'b0, 4'h0, 1'b1, "msb_idle");
    endtask

    task automatic test_lsb_first();
        sel = 2'd1;
        drive_cycle(1'b1, 4'hA, 1'b1, "lsb_load");
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 4'hF, 1'b1, "lsb_bits");
        drive_cycle(1'b0, 4'h0, 1'b1, "lsb_idle");
    endtask

    task automatic test_receiver();
        sel = 2'd0;
        drive_cycle(1'b1, 4'h6, 1'b1, "rx_load");
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 4'h9, 1'b1, "rx_bits");
        drive_cycle(1'b0, 4'h0, 1'b0, "rx_idle");
    endtask

    task automatic test_back_to_back();
        sel = 2'd0;
        drive_cycle(1'b1, 4'h3, 1'b1, "b2b_load");
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 4'hC, 1'b1, "b2b_first_word");
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 4'h0, 1'b1, "b2b_second_word");
        drive_cycle(1'b0, 4'h0, 1'b1, "b2b_idle");
    endtask

    task automatic test_stall();
        sel = 2'd0;
        drive_cycle(1'b1, 4'h9, 1'b1, "stall_load");
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 4'h0, 1'b1, "stall_pre");
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 4'h7, 1'b0, "stall_hold");
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 4'h0, 1'b1, "stall_resume");
        drive_cycle(1'b0, 4'h0, 1'b1, "stall_idle");
    endtask

    task automatic test_reset_mid_word();
        sel = 2'd0;
        drive_cycle(1'b1, 4'hF, 1'b1, "rst_load");
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 4'h0, 1'b1, "rst_pre");
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({o_xv, o_busy, o_x, o_first, o_last, o_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_mid_word: got valid,busy,x,first,last,ready=%b required 000001",
                     {o_xv, o_busy, o_x, o_first, o_last, o_ready});
        end
        sb.delete();
        words.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_cycle(1'b1, 4'h5, 1'b1, "rst_reload");
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 4'h0, 1'b1, "rst_bits");
        drive_cycle(1'b0, 4'h0, 1'b1, "rst_idle");
    endtask

    task automatic test_width1();
        sel = 2'd2;
        drive_cycle(1'b1, 4'h1, 1'b1, "w1_load");
        drive_cycle(1'b1, 4'h0, 1'b1, "w1_bit_b2b");
        drive_cycle(1'b0, 4'h0, 1'b1, "w1_bit0");
        drive_cycle(1'b0, 4'h0, 1'b1, "w1_idle");
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            sel = 2'(s);
            for (int i = 0; i < 150; i++)
                drive_cycle(1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 3) != 0), "rand");
            for (int i = 0; i < 6; i++) drive_cycle(1'b0, 4'($urandom), 1'b1, "rand_drain");
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL rand_drain_empty sel%0d: got %0d pending bits required 0", s, sb.size());
            end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rx        = 4'h0;
        sel       = 2'd0;
        reset     = 1'b1;
        par_valid = 1'b0;
        par_data  = 4'h0;
        ser_en    = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_receiver();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_width1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
